// File: rtl/rht_pkg.sv
// Shared definitions for the register hazard tracker.
//   FWD_RF      : forward-select code meaning "take the register file value"
//   RHT_AW_MAX  : storage width of a stage's destination tag (AW must not exceed it)
//   rht_entry_t : one tracked pipeline stage (valid, wr, ld, dst)
//   ready_stage : first stage at which an entry's result can be forwarded
package rht_pkg;

  localparam int unsigned FWD_RF     = 0;
  localparam int unsigned RHT_AW_MAX = 8;

  // The tag field is sized to the largest supported register-number width, so
  // one struct type serves every AW. Narrower tags are zero-extended on entry.
  typedef struct packed {
    logic                  valid;
    logic                  wr;
    logic                  ld;
    logic [RHT_AW_MAX-1:0] dst;
  } rht_entry_t;

  function automatic int unsigned ready_stage(input logic ld,
                                              input int unsigned alu_rdy,
                                              input int unsigned ld_rdy);
    return ld ? ld_rdy : alu_rdy;
  endfunction

endpackage

// File: rtl/reg_hazard_track_if.sv
// Decode-side bus of the register hazard tracker.
//   master : decode/pipeline control (drives D-stage info, stall, flush; reads selects)
//   slave  : reg_hazard_track
interface reg_hazard_track_if #(
  parameter int unsigned AW     = 5,
  parameter int unsigned NSTAGE = 3,
  parameter int unsigned SW     = $clog2(NSTAGE + 1)
);
  logic [AW-1:0]     rs_D;
  logic [AW-1:0]     rt_D;
  logic              rs_use_D;
  logic              rt_use_D;
  logic              early_D;
  logic [AW-1:0]     dst_D;
  logic              wr_D;
  logic              ld_D;
  logic              d_valid;
  logic [NSTAGE-1:0] stall;
  logic [NSTAGE-1:0] flush;
  logic [SW-1:0]     fwd_a_D;
  logic [SW-1:0]     fwd_b_D;
  logic [SW-1:0]     fwd_a_E;
  logic [SW-1:0]     fwd_b_E;
  logic              hz_stall_D;
  logic [AW-1:0]     dst_W;
  logic              wr_W;

  modport master (
    output rs_D, rt_D, rs_use_D, rt_use_D, early_D, dst_D, wr_D, ld_D, d_valid,
           stall, flush,
    input  fwd_a_D, fwd_b_D, fwd_a_E, fwd_b_E, hz_stall_D, dst_W, wr_W
  );

  modport slave (
    input  rs_D, rt_D, rs_use_D, rt_use_D, early_D, dst_D, wr_D, ld_D, d_valid,
           stall, flush,
    output fwd_a_D, fwd_b_D, fwd_a_E, fwd_b_E, hz_stall_D, dst_W, wr_W
  );
endinterface

// File: rtl/rht_stage.sv
// One tracked pipeline entry.
//   clk, reset : clock, asynchronous active-low reset
//   stall      : hold the entry
//   flush      : clear the entry (beats stall)
//   bubble     : load an empty entry instead of d
//   d / q      : entry from the previous stage / held entry
module rht_stage
  import rht_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  input  logic       flush,
  input  logic       bubble,
  input  rht_entry_t d,
  output rht_entry_t q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       q <= '0;
    else if (flush)   q <= '0;
    else if (!stall)  q <= bubble ? '0 : d;
  end

endmodule

// File: rtl/reg_hazard_track.sv
// Destination-tag tracking, operand forwarding selects and load-use stall for
// NSTAGE pipeline stages after decode (stage 1 = E, 2 = M, 3 = W, ...).
//   clk, reset    : clock, asynchronous active-low reset
//   bus (slave)   : D-stage sources/destination, per-stage stall/flush,
//                   forward selects, hz_stall_D, dst_W/wr_W
//   stall_cnt_clr : synchronous clear of stall_cnt   (RHT_STALL_CNT_EN only)
//   stall_cnt     : saturating count of hazard cycles (RHT_STALL_CNT_EN only)
// Optional feature macro: RHT_STALL_CNT_EN
module reg_hazard_track
  import rht_pkg::*;
#(
  parameter int unsigned AW      = 5,
  parameter int unsigned NSTAGE  = 3,
  parameter int unsigned ALU_RDY = 2,
  parameter int unsigned LD_RDY  = 3,
  parameter int unsigned SW      = $clog2(NSTAGE + 1)
) (
  input  logic                clk,
  input  logic                reset,
`ifdef RHT_STALL_CNT_EN
  input  logic                stall_cnt_clr,
  output logic [31:0]         stall_cnt,
`endif
  reg_hazard_track_if.slave   bus
);

  rht_entry_t    d_ent;
  rht_entry_t    st [1:NSTAGE];
  logic [AW-1:0] rs_E, rt_E;
  logic          rs_use_E, rt_use_E;
  logic          hz;

  function automatic logic is_match(input rht_entry_t e, input logic [AW-1:0] r);
    return e.valid && e.wr && (e.dst == RHT_AW_MAX'(r)) && (r != '0);
  endfunction

  // Scan oldest to youngest so the youngest match is the one that sticks.
  function automatic logic [SW-1:0] fwd_sel(input rht_entry_t s [1:NSTAGE],
                                            input logic [AW-1:0] r,
                                            input logic use_r);
    logic        hit;
    int unsigned kk, rdy;
    hit = 1'b0;
    kk  = 0;
    rdy = 0;
    for (int unsigned k = NSTAGE; k >= 2; k--) begin
      if (use_r && is_match(s[k], r)) begin
        hit = 1'b1;
        kk  = k;
        rdy = ready_stage(s[k].ld, ALU_RDY, LD_RDY);
      end
    end
    return (hit && kk >= rdy) ? SW'(kk) : SW'(FWD_RF);
  endfunction

  // Late consumers read in E, one stage after D, so they tolerate one more
  // stage of distance than branch-style consumers reading in D.
  function automatic logic src_hazard(input rht_entry_t s [1:NSTAGE],
                                      input logic [AW-1:0] r,
                                      input logic use_r,
                                      input logic early);
    logic        hit;
    int unsigned kk, rdy;
    hit = 1'b0;
    kk  = 0;
    rdy = 0;
    for (int unsigned k = NSTAGE; k >= 1; k--) begin
      if (use_r && is_match(s[k], r)) begin
        hit = 1'b1;
        kk  = k;
        rdy = ready_stage(s[k].ld, ALU_RDY, LD_RDY);
      end
    end
    return hit && (early ? (rdy > kk) : (rdy > kk + 1));
  endfunction

  always_comb begin
    d_ent = '0;
    if (bus.d_valid) begin
      d_ent.valid = 1'b1;
      d_ent.wr    = bus.wr_D;
      d_ent.ld    = bus.ld_D;
      d_ent.dst   = RHT_AW_MAX'(bus.dst_D);
    end
  end

  for (genvar k = 1; k <= NSTAGE; k++) begin : g_stage
    if (k == 1) begin : g_e
      rht_stage u_stage (
        .clk(clk), .reset(reset), .stall(bus.stall[0]), .flush(bus.flush[0]),
        .bubble(hz), .d(d_ent), .q(st[1])
      );
    end else begin : g_late
      rht_stage u_stage (
        .clk(clk), .reset(reset), .stall(bus.stall[k-1]), .flush(bus.flush[k-1]),
        .bubble(1'b0), .d(st[k-1]), .q(st[k])
      );
    end
  end

  // E-stage source operands follow stage 1's stall/flush/bubble rules.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || bus.flush[0]) begin
      rs_E     <= '0;
      rt_E     <= '0;
      rs_use_E <= 1'b0;
      rt_use_E <= 1'b0;
    end else if (!bus.stall[0]) begin
      if (bus.d_valid && !hz) begin
        rs_E     <= bus.rs_D;
        rt_E     <= bus.rt_D;
        rs_use_E <= bus.rs_use_D;
        rt_use_E <= bus.rt_use_D;
      end else begin
        rs_E     <= '0;
        rt_E     <= '0;
        rs_use_E <= 1'b0;
        rt_use_E <= 1'b0;
      end
    end
  end

  always_comb begin
    hz = bus.d_valid &&
         (src_hazard(st, bus.rs_D, bus.rs_use_D, bus.early_D) ||
          src_hazard(st, bus.rt_D, bus.rt_use_D, bus.early_D));
  end

  assign bus.hz_stall_D = hz;
  assign bus.fwd_a_E    = fwd_sel(st, rs_E, rs_use_E);
  assign bus.fwd_b_E    = fwd_sel(st, rt_E, rt_use_E);
  assign bus.fwd_a_D    = bus.early_D ? fwd_sel(st, bus.rs_D, bus.rs_use_D) : SW'(FWD_RF);
  assign bus.fwd_b_D    = bus.early_D ? fwd_sel(st, bus.rt_D, bus.rt_use_D) : SW'(FWD_RF);
  assign bus.dst_W      = st[NSTAGE].dst[AW-1:0];
  assign bus.wr_W       = st[NSTAGE].valid & st[NSTAGE].wr;

`ifdef RHT_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         stall_cnt <= '0;
    else if (stall_cnt_clr)             stall_cnt <= '0;
    else if (hz && (stall_cnt != '1))   stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_reg_hazard_track.sv
module tb_reg_hazard_track;
  localparam int unsigned AW      = 5;
  localparam int unsigned NSTAGE  = 3;
  localparam int unsigned ALU_RDY = 2;
  localparam int unsigned LD_RDY  = 3;
  localparam int unsigned SW      = $clog2(NSTAGE + 1);

  logic clk = 1'b0;
  logic reset;

  reg_hazard_track_if #(.AW(AW), .NSTAGE(NSTAGE), .SW(SW)) bus ();

`ifdef RHT_STALL_CNT_EN
  logic        stall_cnt_clr;
  logic [31:0] stall_cnt;
`endif

  reg_hazard_track #(
    .AW(AW), .NSTAGE(NSTAGE), .ALU_RDY(ALU_RDY), .LD_RDY(LD_RDY), .SW(SW)
  ) dut (
    .clk(clk),
    .reset(reset),
`ifdef RHT_STALL_CNT_EN
    .stall_cnt_clr(stall_cnt_clr),
    .stall_cnt(stall_cnt),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: a plain array of in-flight instructions, index = stage.
  typedef struct {
    bit          valid;
    bit          wr;
    bit          ld;
    int unsigned dst;
  } m_ent_t;

  m_ent_t      pipe [1:NSTAGE];
  int unsigned e_rs, e_rt;
  bit          e_rsu, e_rtu;
  int unsigned m_cnt;
  bit          x_hz;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  function automatic int unsigned young(int unsigned r, bit u, int unsigned lo);
    if (!u || r == 0) return 0;
    for (int unsigned k = lo; k <= NSTAGE; k++)
      if (pipe[k].valid && pipe[k].wr && pipe[k].dst == r) return k;
    return 0;
  endfunction

  function automatic int unsigned rdy(int unsigned k);
    return pipe[k].ld ? LD_RDY : ALU_RDY;
  endfunction

  function automatic int unsigned fsel(int unsigned r, bit u);
    int unsigned k;
    k = young(r, u, 2);
    return (k != 0 && k >= rdy(k)) ? k : 0;
  endfunction

  function automatic bit src_hz(int unsigned r, bit u, bit early);
    int unsigned k;
    k = young(r, u, 1);
    if (k == 0) return 0;
    return early ? (rdy(k) > k) : (rdy(k) > k + 1);
  endfunction

  task automatic model_clear();
    for (int unsigned k = 1; k <= NSTAGE; k++) pipe[k] = '{default: 0};
    e_rs = 0; e_rt = 0; e_rsu = 0; e_rtu = 0;
    m_cnt = 0;
    x_hz  = 0;
  endtask

  task automatic set_d(int unsigned rs, int unsigned rt, bit rsu, bit rtu, bit early,
                       int unsigned dst, bit wr, bit ld, bit valid);
    bus.rs_D = AW'(rs);       bus.rt_D = AW'(rt);
    bus.rs_use_D = rsu;       bus.rt_use_D = rtu;
    bus.early_D = early;      bus.dst_D = AW'(dst);
    bus.wr_D = wr;            bus.ld_D = ld;
    bus.d_valid = valid;
  endtask

  task automatic nop();
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".hz"},    32'(bus.hz_stall_D), 0);
    check({tag, ".fa_D"},  32'(bus.fwd_a_D), 0);
    check({tag, ".fb_D"},  32'(bus.fwd_b_D), 0);
    check({tag, ".fa_E"},  32'(bus.fwd_a_E), 0);
    check({tag, ".fb_E"},  32'(bus.fwd_b_E), 0);
    check({tag, ".dst_W"}, 32'(bus.dst_W), 0);
    check({tag, ".wr_W"},  32'(bus.wr_W), 0);
  endtask

  // Compare every output against the model, away from the active edge.
  task automatic eval();
    @(negedge clk);
    x_hz = bus.d_valid && (src_hz(bus.rs_D, bus.rs_use_D, bus.early_D) ||
                           src_hz(bus.rt_D, bus.rt_use_D, bus.early_D));
    check("hz_stall_D", 32'(bus.hz_stall_D), 32'(x_hz));
    check("fwd_a_D", 32'(bus.fwd_a_D), bus.early_D ? fsel(bus.rs_D, bus.rs_use_D) : 0);
    check("fwd_b_D", 32'(bus.fwd_b_D), bus.early_D ? fsel(bus.rt_D, bus.rt_use_D) : 0);
    check("fwd_a_E", 32'(bus.fwd_a_E), fsel(e_rs, e_rsu));
    check("fwd_b_E", 32'(bus.fwd_b_E), fsel(e_rt, e_rtu));
    check("dst_W", 32'(bus.dst_W), pipe[NSTAGE].dst);
    check("wr_W", 32'(bus.wr_W), 32'(pipe[NSTAGE].valid && pipe[NSTAGE].wr));
`ifdef RHT_STALL_CNT_EN
    check("stall_cnt", stall_cnt, m_cnt);
`endif
  endtask

  // Advance the model on the same edge the DUT uses.
  task automatic tick();
    @(posedge clk);
    for (int unsigned k = NSTAGE; k >= 1; k--) begin
      if (bus.flush[k-1]) pipe[k] = '{default: 0};
      else if (!bus.stall[k-1]) begin
        if (k > 1) pipe[k] = pipe[k-1];
        else if (bus.d_valid && !x_hz)
          pipe[1] = '{valid: 1'b1, wr: bus.wr_D, ld: bus.ld_D, dst: bus.dst_D};
        else pipe[1] = '{default: 0};
      end
    end
    if (bus.flush[0] || (!bus.stall[0] && !(bus.d_valid && !x_hz))) begin
      e_rs = 0; e_rt = 0; e_rsu = 0; e_rtu = 0;
    end else if (!bus.stall[0]) begin
      e_rs = bus.rs_D; e_rt = bus.rt_D; e_rsu = bus.rs_use_D; e_rtu = bus.rt_use_D;
    end
`ifdef RHT_STALL_CNT_EN
    if (stall_cnt_clr) m_cnt = 0;
    else if (x_hz && m_cnt != 32'hffffffff) m_cnt++;
`endif
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    nop();
    bus.stall = '0;
    bus.flush = '0;
`ifdef RHT_STALL_CNT_EN
    stall_cnt_clr = 1'b0;
`endif
    model_clear();
    #12;
    check_zero("reset");
`ifdef RHT_STALL_CNT_EN
    check("reset.stall_cnt", stall_cnt, 0);
`endif
    @(posedge clk); #1;
    reset = 1'b1;

    // ALU result reuse: no stall, E operand forwarded from M.
    set_d(0, 0, 0, 0, 0, 3, 1, 0, 1); eval(); tick();
    set_d(3, 0, 1, 0, 0, 0, 0, 0, 1); eval(); check("alu.hz", 32'(bus.hz_stall_D), 0); tick();
    nop(); eval(); check("alu.fa_E", 32'(bus.fwd_a_E), 2); tick();

    // Load-use: one stall, bubble in E, then forward from W.
    set_d(0, 0, 0, 0, 0, 5, 1, 1, 1); eval(); tick();
    set_d(0, 5, 0, 1, 0, 0, 0, 0, 1); eval(); check("lu.hz1", 32'(bus.hz_stall_D), 1); tick();
    eval(); check("lu.hz2", 32'(bus.hz_stall_D), 0); check("lu.bubble_fb_E", 32'(bus.fwd_b_E), 0); tick();
    nop(); eval(); check("lu.fb_E", 32'(bus.fwd_b_E), 3); tick();

    // Branch after ALU op: one stall, then early forward from M.
    set_d(0, 0, 0, 0, 0, 7, 1, 0, 1); eval(); tick();
    set_d(7, 0, 1, 0, 1, 0, 0, 0, 1); eval(); check("br_alu.hz1", 32'(bus.hz_stall_D), 1); tick();
    eval(); check("br_alu.hz2", 32'(bus.hz_stall_D), 0); check("br_alu.fa_D", 32'(bus.fwd_a_D), 2); tick();

    // Branch after load: two stalls, then early forward from W.
    set_d(0, 0, 0, 0, 0, 7, 1, 1, 1); eval(); tick();
    set_d(7, 0, 1, 0, 1, 0, 0, 0, 1); eval(); check("br_ld.hz1", 32'(bus.hz_stall_D), 1); tick();
    eval(); check("br_ld.hz2", 32'(bus.hz_stall_D), 1); tick();
    eval(); check("br_ld.hz3", 32'(bus.hz_stall_D), 0); check("br_ld.fa_D", 32'(bus.fwd_a_D), 3); tick();

    // Register zero never matches.
    set_d(0, 0, 0, 0, 0, 0, 1, 0, 1); eval(); tick();
    nop(); eval(); tick();
    set_d(0, 0, 1, 1, 1, 0, 0, 0, 1); eval();
    check("r0.hz", 32'(bus.hz_stall_D), 0); check("r0.fa_D", 32'(bus.fwd_a_D), 0);
    check("r0.fb_D", 32'(bus.fwd_b_D), 0); tick();
    nop(); eval(); check("r0.fa_E", 32'(bus.fwd_a_E), 0); tick();

    // Flush beats stall on a matching M entry.
    set_d(0, 0, 0, 0, 0, 9, 1, 0, 1); eval(); tick();
    set_d(9, 0, 1, 0, 0, 0, 0, 0, 1); eval(); tick();
    nop(); bus.stall = '1; bus.flush = NSTAGE'(2);
    eval(); check("fl.fa_E_before", 32'(bus.fwd_a_E), 2); tick();
    bus.stall = '0; bus.flush = '0;
    eval(); check("fl.fa_E_after", 32'(bus.fwd_a_E), 0); tick();

    // Asynchronous reset mid-stream.
    set_d(0, 0, 0, 0, 0, 5, 1, 1, 1); eval(); tick();
    set_d(0, 5, 0, 1, 0, 0, 0, 0, 1); eval(); check("mid.hz", 32'(bus.hz_stall_D), 1);
    #2 reset = 1'b0;
    #1 model_clear();
    check_zero("midrst");
    @(posedge clk); #1;
    reset = 1'b1;

`ifdef RHT_STALL_CNT_EN
    for (int i = 0; i < 5; i++) begin
      set_d(0, 0, 0, 0, 0, 5, 1, 1, 1); eval(); tick();
      set_d(0, 5, 0, 1, 0, 0, 0, 0, 1); eval(); tick();
      eval(); tick();
    end
    nop(); eval(); check("cnt.five", stall_cnt, 5); tick();
    set_d(0, 0, 0, 0, 0, 5, 1, 1, 1); eval(); tick();
    set_d(0, 5, 0, 1, 0, 0, 0, 0, 1); stall_cnt_clr = 1'b1; eval(); tick();
    stall_cnt_clr = 1'b0; eval(); check("cnt.clr", stall_cnt, 0); tick();
`endif

    // Randomized traffic on a small register pool to provoke overlaps.
    for (int n = 0; n < 600; n++) begin
      set_d($urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 3),
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4,
            $urandom_range(0, 9) < 8);
      for (int i = 0; i < int'(NSTAGE); i++) begin
        bus.stall[i] = ($urandom_range(0, 9) == 0);
        bus.flush[i] = ($urandom_range(0, 14) == 0);
      end
`ifdef RHT_STALL_CNT_EN
      stall_cnt_clr = ($urandom_range(0, 19) == 0);
`endif
      eval();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
